// File: rtl/uart_stream_bridge_if.sv
// ============================================================================
// Module  : uart_stream_bridge_if
// Brief   : AXI-stream style valid/ready byte channel used by the UART bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_stream_bridge_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/uart_stream_bridge.sv
// ============================================================================
// Module  : uart_stream_bridge
// Brief   : Full-duplex UART <-> AXI-stream bridge, runtime baud/parity/stop.
//           Define UART_BRIDGE_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_stream_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_BITS   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [CLK_BITS-1:0] clk_per_bit,
  input  wire logic [1:0]          parity_mode,
  input  wire logic                stop2,
  uart_stream_bridge_if.slave      s_axis,
  uart_stream_bridge_if.master     m_axis,
  output logic                     rx_frame_err,
  output logic                     rx_parity_err,
  output logic                     rx_overrun,
  output logic                     tx_busy,
  input  wire logic                uart_rx,
  output logic                     uart_tx
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_stream_bridge: DATA_WIDTH must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_stream_bridge: FIFO_DEPTH must be a power of 2 >= 2");
  end

  localparam logic [CLK_BITS-1:0] CPB_MIN = CLK_BITS'(4);
  localparam logic [CLK_BITS-1:0] CPB_ONE = CLK_BITS'(1);
  localparam logic [3:0]          LAST_IDX = 4'(DATA_WIDTH - 1);

  localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                         TX_PAR  = 3'd3, TX_STOP  = 3'd4;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
                         RX_PAR  = 3'd3, RX_STOP  = 3'd4, RX_BRK   = 3'd5;

  logic [CLK_BITS-1:0] cpb_eff;
  logic                par_en;
  assign cpb_eff = (clk_per_bit < CPB_MIN) ? CPB_MIN : clk_per_bit;
  assign par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);

  // ---------------- TX ----------------
  logic [2:0]            tx_state;
  logic [CLK_BITS-1:0]   tx_cpb, tx_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [3:0]            tx_idx;
  logic                  tx_par, tx_par_en, tx_stop2, tx_stop_second, tx_alive;

  assign s_axis.tready = tx_alive && (tx_state == TX_IDLE);
  assign tx_busy       = (tx_state != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state       <= TX_IDLE;
      tx_cpb         <= CPB_MIN;
      tx_cnt         <= '0;
      tx_shift       <= '0;
      tx_idx         <= '0;
      tx_par         <= 1'b0;
      tx_par_en      <= 1'b0;
      tx_stop2       <= 1'b0;
      tx_stop_second <= 1'b0;
      tx_alive       <= 1'b0;
      uart_tx        <= 1'b1;
    end else begin
      tx_alive <= 1'b1;
      if (tx_state == TX_IDLE) begin
        if (s_axis.tvalid && s_axis.tready) begin
          tx_shift  <= s_axis.tdata;
          tx_par    <= (^s_axis.tdata) ^ parity_mode[1];
          tx_par_en <= par_en;
          tx_stop2  <= stop2;
          tx_cpb    <= cpb_eff;
          tx_cnt    <= cpb_eff - CPB_ONE;
          uart_tx   <= 1'b0;
          tx_state  <= TX_START;
        end
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CPB_ONE;
      end else begin
        tx_cnt <= tx_cpb - CPB_ONE;
        case (tx_state)
          TX_START: begin
            uart_tx  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_idx == LAST_IDX) begin
              tx_stop_second <= 1'b0;
              uart_tx        <= tx_par_en ? tx_par : 1'b1;
              tx_state       <= tx_par_en ? TX_PAR : TX_STOP;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + 4'd1;
            end
          end
          TX_PAR: begin
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_stop2 && !tx_stop_second) tx_stop_second <= 1'b1;
            else                             tx_state       <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  logic [2:0]            rx_state;
  logic                  rx_s1, rx_s2, rx_s3;
  logic [CLK_BITS-1:0]   rx_cpb, rx_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [3:0]            rx_idx;
  logic                  rx_par_en, rx_par_odd, rx_par_bad;
  logic                  rx_push, rx_pop;

  assign rx_push = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s2 && !rx_par_bad;
  assign rx_pop  = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_s3         <= 1'b1;
      rx_cpb        <= CPB_MIN;
      rx_cnt        <= '0;
      rx_shift      <= '0;
      rx_idx        <= '0;
      rx_par_en     <= 1'b0;
      rx_par_odd    <= 1'b0;
      rx_par_bad    <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_s1         <= uart_rx;
      rx_s2         <= rx_s1;
      rx_s3         <= rx_s2;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (!rx_s2 && rx_s3) begin
          rx_cpb     <= cpb_eff;
          rx_cnt     <= (cpb_eff >> 1) - CPB_ONE;
          rx_par_en  <= par_en;
          rx_par_odd <= parity_mode[1];
          rx_par_bad <= 1'b0;
          rx_state   <= RX_START;
        end
      end else if (rx_state == RX_BRK) begin
        if (rx_s2) rx_state <= RX_IDLE;
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CPB_ONE;
      end else begin
        rx_cnt <= rx_cpb - CPB_ONE;
        case (rx_state)
          RX_START: begin
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
          RX_DATA: begin
            rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
            if (rx_idx == LAST_IDX) rx_state <= rx_par_en ? RX_PAR : RX_STOP;
            else                    rx_idx   <= rx_idx + 4'd1;
          end
          RX_PAR: begin
            // Even: data^parity must be 0; odd: must be 1.
            if ((^rx_shift) ^ rx_s2 ^ rx_par_odd) begin
              rx_par_bad    <= 1'b1;
              rx_parity_err <= 1'b1;
            end
            rx_state <= RX_STOP;
          end
          RX_STOP: begin
            if (!rx_s2) begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_BRK;
            end else begin
              rx_state <= RX_IDLE;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX buffer ----------------
`ifdef UART_BRIDGE_RX_FIFO_EN
  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, wr_ok;

  assign full  = (count == FULL_CNT);
  assign wr_ok = rx_push && (!full || rx_pop);

  always_ff @(posedge clk) begin
    if (wr_ok) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_push && full && !rx_pop;
      if (wr_ok)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rx_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rx_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign m_axis.tvalid = (count != '0);
  assign m_axis.tdata  = m_axis.tvalid ? fifo_mem[rd_ptr] : '0;
`else
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data  <= '0;
      hold_full  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_push && hold_full && !rx_pop;
      if (rx_push && (!hold_full || rx_pop)) begin
        hold_data <= rx_shift;
        hold_full <= 1'b1;
      end else if (rx_pop) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = hold_full;
  assign m_axis.tdata  = hold_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_stream_bridge.sv
// ============================================================================
// Module  : tb_uart_stream_bridge
// Brief   : Directed self-checking bench for uart_stream_bridge (clk_per_bit=4).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_stream_bridge;
  localparam int DW = 8;
`ifdef UART_BRIDGE_RX_FIFO_EN
  localparam int KEEP = 8;
`else
  localparam int KEEP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpb = 16'd4;
  logic [1:0]  pm = 2'b00;
  logic        stop2 = 1'b0;
  logic        rx_frame_err, rx_parity_err, rx_overrun, tx_busy, uart_tx;
  wire logic   uart_rx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  int n_tests = 0, n_fail = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;
  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_stream_bridge_if #(.DATA_WIDTH(DW)) s_axis ();
  uart_stream_bridge_if #(.DATA_WIDTH(DW)) m_axis ();

  uart_stream_bridge #(.DATA_WIDTH(DW), .CLK_BITS(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .parity_mode(pm), .stop2(stop2),
    .s_axis(s_axis), .m_axis(m_axis),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun), .tx_busy(tx_busy),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and RX scoreboard consumer.
  always @(negedge clk) begin
    if (rx_frame_err)  n_fe++;
    if (rx_parity_err) n_pe++;
    if (rx_overrun)    n_ov++;
    if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1)
      chk("rx_byte", {24'd0, m_axis.tdata},
          (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'hDEAD_BEEF);
  end

  task automatic rx_hold(input logic b, input int n);
    rx_drv = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par, input logic stp);
    rx_hold(1'b0, 4);
    for (int i = 0; i < 8; i++) rx_hold(d[i], 4);
    if (pm == 2'b01 || pm == 2'b10) rx_hold(par, 4);
    rx_hold(stp, 4);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (rx_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rx_q.size(), 0);
  endtask

  task automatic tx_frame(input logic [7:0] d);
    logic exp_bits[$];
    int   n, nbits;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pm == 2'b01) exp_bits.push_back(^d);
    if (pm == 2'b10) exp_bits.push_back(~^d);
    exp_bits.push_back(1'b1);
    if (stop2) exp_bits.push_back(1'b1);
    nbits = exp_bits.size();
    n = 0;
    @(negedge clk);
    while (s_axis.tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_before", s_axis.tready, 1);
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis.tvalid = 1'b0;
    chk("tx_busy", tx_busy, 1);
    n = 0;
    @(negedge clk);
    while (s_axis.tready === 1'b0 && n < 200) begin
      if (n % 4 == 2 && exp_bits.size() != 0)
        chk($sformatf("tx_bit%0d", n / 4), uart_tx, exp_bits.pop_front());
      n++;
      @(negedge clk);
    end
    chk("tx_ready_low_cycles", n, nbits * 4);
    chk("tx_bits_left", exp_bits.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, pe0, ov0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tready", s_axis.tready, 0);
    chk("rst_m_tvalid", m_axis.tvalid, 0);
    chk("rst_m_tdata", m_axis.tdata, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    rst = 1'b0;
    #1 chk("rel_tready_pre_edge", s_axis.tready, 0);
    @(posedge clk);
    #1 chk("rel_tready_post_edge", s_axis.tready, 1);

    // TX 0xA5, no parity, one stop bit: 10 bits, 40 cycles.
    tx_frame(8'hA5);
    // TX with odd parity and two stop bits: 12 bits.
    pm = 2'b10; stop2 = 1'b1;
    tx_frame(8'h5A);
    stop2 = 1'b0;

    // Loopback with even parity.
    pm = 2'b01; loop_en = 1'b1;
    fe0 = n_fe; pe0 = n_pe;
    rx_q.push_back(8'h3C);
    tx_frame(8'h3C);
    wait_drain("loop_drain");
    repeat (4) @(negedge clk);
    loop_en = 1'b0;
    chk("loop_no_fe", n_fe - fe0, 0);
    chk("loop_no_pe", n_pe - pe0, 0);

    // Bad even parity on 0x01.
    fe0 = n_fe; pe0 = n_pe;
    rx_frame(8'h01, 1'b0, 1'b1);
    rx_hold(1'b1, 6);
    chk("par_err_pulses", n_pe - pe0, 1);
    chk("par_no_fe", n_fe - fe0, 0);
    chk("par_tvalid", m_axis.tvalid, 0);

    // Framing error followed by a break, then a clean frame.
    pm = 2'b00;
    fe0 = n_fe; pe0 = n_pe;
    rx_frame(8'h55, 1'b0, 1'b0);
    rx_hold(1'b0, 20);
    rx_hold(1'b1, 8);
    chk("frm_err_pulses", n_fe - fe0, 1);
    chk("frm_tvalid", m_axis.tvalid, 0);
    rx_q.push_back(8'h66);
    rx_frame(8'h66, 1'b0, 1'b1);
    rx_hold(1'b1, 4);
    wait_drain("frm_next_drain");
    chk("frm_next_no_fe", n_fe - fe0, 1);
    chk("frm_no_pe", n_pe - pe0, 0);

    // Overrun: nine bytes with the sink stalled.
    @(posedge clk);
    #1 m_axis.tready = 1'b0;
    @(negedge clk);
    ov0 = n_ov;
    for (int i = 0; i < 9; i++) begin
      if (i < KEEP) rx_q.push_back(8'h10 + 8'(i));
      rx_frame(8'h10 + 8'(i), 1'b0, 1'b1);
      rx_hold(1'b1, 2);
    end
    rx_hold(1'b1, 4);
    chk("ovr_count", n_ov - ov0, 9 - KEEP);
    chk("ovr_tvalid", m_axis.tvalid, 1);
    chk("ovr_head", m_axis.tdata, 8'h10);
    @(posedge clk);
    #1 m_axis.tready = 1'b1;
    wait_drain("ovr_drain");
    @(negedge clk);
    chk("ovr_empty", m_axis.tvalid, 0);

    // Reset in the middle of a 0xFF transmission.
    @(negedge clk);
    s_axis.tdata  = 8'hFF;
    s_axis.tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis.tvalid = 1'b0;
    @(negedge clk);
    chk("mid_start_low", uart_tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx_high", uart_tx, 1);
    chk("mid_rst_tready", s_axis.tready, 0);
    chk("mid_rst_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rel_tready_pre", s_axis.tready, 0);
    @(posedge clk);
    #1 chk("mid_rel_tready_post", s_axis.tready, 1);
    tx_frame(8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
